// File: rtl/vbuf_pkg.sv
// Shared frame-buffer constants and types for the video-buffer blitter and scan-out AGU.
package vbuf_pkg;

    localparam int unsigned VBUF_W    = 320;
    localparam int unsigned VBUF_H    = 240;
    localparam int unsigned VBUF_SZ   = VBUF_W * VBUF_H;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned SPR_DIM_W = 7;
    localparam int unsigned POS_W     = 9;
    localparam int unsigned CLIP_W    = 10;

    // Video buffer sits at the bottom of the SRAM; sprite images follow it.
    localparam int unsigned VBUF_BASE = 0;
    localparam int unsigned IMG_BASE  = VBUF_SZ;

    localparam logic [DATA_W-1:0] KEY_PIXEL = 12'h0F0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } blit_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    src_base;
        logic [SPR_DIM_W-1:0] spr_w;
        logic [SPR_DIM_W-1:0] spr_h;
        logic [POS_W-1:0]     dst_x;
        logic [POS_W-1:0]     dst_y;
    } blit_req_t;

endpackage

// File: rtl/vbuf_blitter_addr_gen.sv
// Source/destination address and clip flag for sprite pixel (i, j).
module blit_addr_gen
    import vbuf_pkg::*;
#(
    parameter int unsigned BUF_W = vbuf_pkg::VBUF_W,
    parameter int unsigned BUF_H = vbuf_pkg::VBUF_H
) (
    input  logic [ADDR_W-1:0]    src_base,
    input  logic [SPR_DIM_W-1:0] spr_w,
    input  logic [POS_W-1:0]     dst_x,
    input  logic [POS_W-1:0]     dst_y,
    input  logic [SPR_DIM_W-1:0] i,
    input  logic [SPR_DIM_W-1:0] j,
    output logic [ADDR_W-1:0]    src_addr_c,
    output logic [ADDR_W-1:0]    dst_addr_c,
    output logic                 in_bounds_c
);

    logic [CLIP_W-1:0] col;
    logic [CLIP_W-1:0] row;

    // 10-bit sums so a sprite hanging off the right/bottom edge cannot wrap back in.
    assign col = CLIP_W'(dst_x) + CLIP_W'(i);
    assign row = CLIP_W'(dst_y) + CLIP_W'(j);

    assign in_bounds_c = (col < CLIP_W'(BUF_W)) && (row < CLIP_W'(BUF_H));
    assign src_addr_c  = src_base + ADDR_W'(j) * ADDR_W'(spr_w) + ADDR_W'(i);
    assign dst_addr_c  = ADDR_W'(row) * ADDR_W'(BUF_W) + ADDR_W'(col);

endmodule

// File: rtl/vbuf_blitter.sv
// Sprite blitter: copies a W x H sprite into the video buffer with key-colour skip and edge clipping.
module vbuf_blitter #(
    parameter int unsigned VBUF_W     = vbuf_pkg::VBUF_W,
    parameter int unsigned VBUF_H     = vbuf_pkg::VBUF_H,
    parameter int unsigned ADDR_WIDTH = vbuf_pkg::ADDR_W,
    parameter int unsigned DATA_WIDTH = vbuf_pkg::DATA_W,
    parameter logic [DATA_WIDTH-1:0] KEY_PIXEL = vbuf_pkg::KEY_PIXEL
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [6:0]            spr_w,
    input  logic [6:0]            spr_h,
    input  logic [8:0]            dst_x,
    input  logic [8:0]            dst_y,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    import vbuf_pkg::*;

    blit_state_t          state, state_d;
    blit_req_t            req, req_d;
    logic [SPR_DIM_W-1:0] col_i, col_i_d, row_j, row_j_d;
    logic                 slot_go, slot_go_d;
    logic [DATA_WIDTH-1:0] pix, pix_d, wr_pix;
    logic                 busy_d, done_d, en_d, we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] din_d;
    logic [ADDR_W-1:0]    src_addr_c, dst_addr_c;
    logic                 in_bounds_c;
    logic                 last_col, last_pix, advance;

    assign last_col = (col_i == req.spr_w - 7'd1);
    assign last_pix = last_col && (row_j == req.spr_h - 7'd1);
    assign advance  = (state == WRITE) && slot_go;

    // Request latch and pixel counters; the address generator sees the next-cycle values.
    always_comb begin
        req_d   = req;
        col_i_d = col_i;
        row_j_d = row_j;
        if (state == IDLE && start) begin
            req_d.src_base = ADDR_W'(src_base);
            req_d.spr_w    = spr_w;
            req_d.spr_h    = spr_h;
            req_d.dst_x    = dst_x;
            req_d.dst_y    = dst_y;
            col_i_d        = '0;
            row_j_d        = '0;
        end else if (advance && !last_col) begin
            col_i_d = col_i + 7'd1;
        end else if (advance) begin
            col_i_d = '0;
            row_j_d = row_j + 7'd1;
        end
    end

    blit_addr_gen #(
        .BUF_W (VBUF_W),
        .BUF_H (VBUF_H)
    ) u_addr_gen (
        .src_base    (req_d.src_base),
        .spr_w       (req_d.spr_w),
        .dst_x       (req_d.dst_x),
        .dst_y       (req_d.dst_y),
        .i           (col_i_d),
        .j           (row_j_d),
        .src_addr_c  (src_addr_c),
        .dst_addr_c  (dst_addr_c),
        .in_bounds_c (in_bounds_c)
    );

    // Next state and registered outputs for the coming cycle; slot_go marks an unpaused slot.
    always_comb begin
        state_d   = state;
        slot_go_d = 1'b0;
        pix_d     = pix;
        en_d      = 1'b0;
        we_d      = 1'b0;
        addr_d    = sram_addr;
        din_d     = sram_din;
        wr_pix    = (state == LATCH) ? sram_dout : pix;

        case (state)
            IDLE:    if (start) state_d = (spr_w == '0 || spr_h == '0) ? DONE : READ;
            READ:    if (slot_go) state_d = LATCH;
            LATCH: begin
                state_d = WRITE;
                pix_d   = sram_dout;
            end
            WRITE:   if (slot_go) state_d = last_pix ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == READ && !pause) begin
            slot_go_d = 1'b1;
            en_d      = 1'b1;
            addr_d    = ADDR_WIDTH'(src_addr_c);
        end
        if (state_d == WRITE && !pause) begin
            slot_go_d = 1'b1;
            if (wr_pix != KEY_PIXEL && in_bounds_c) begin
                en_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = ADDR_WIDTH'(dst_addr_c);
                din_d  = wr_pix;
            end
        end

        busy_d = (state_d == READ) || (state_d == LATCH) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            req       <= '0;
            col_i     <= '0;
            row_j     <= '0;
            slot_go   <= 1'b0;
            pix       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
        end else begin
            state     <= state_d;
            req       <= req_d;
            col_i     <= col_i_d;
            row_j     <= row_j_d;
            slot_go   <= slot_go_d;
            pix       <= pix_d;
            busy      <= busy_d;
            done      <= done_d;
            sram_en   <= en_d;
            sram_we   <= we_d;
            sram_addr <= addr_d;
            sram_din  <= din_d;
        end
    end

endmodule
